// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receiver and the command decoder.
// Optional drop counter enabled by defining UART_RX_FIFO_STATS_EN.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_data,
  input  logic                     rd_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_overflow
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, drop;

  // Status is derived from the registered pointers only; the MSB is the wrap flag.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

  assign pop  = !empty && rd_ready;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = drop || (overflow_q && !clr_overflow);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left unreset; only pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (reset && !flush && push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_overflow)                          drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 16'hFFFF)   drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based reference model.
// Define UART_RX_FIFO_STATS_EN to also exercise the drop counter.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset, wr_en, rd_ready, flush, clr_overflow;
  logic [DW-1:0] wr_data;
  logic          rd_valid, full, empty, overflow;
  logic [DW-1:0] rd_data;
  logic [$clog2(DEPTH):0] count;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0]   drop_cnt;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .flush(flush), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .clr_overflow(clr_overflow)
`ifdef UART_RX_FIFO_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored bytes plus sticky flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] popped[$];
  logic          m_ovf;
  int            m_drops;
  int            pass_cnt = 0;
  int            total    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
    chk({tag, "_data"},  32'(rd_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, "_count"}, 32'(count),    32'(mq.size()));
    chk({tag, "_full"},  32'(full),     32'(mq.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty),    32'(mq.size() == 0));
    chk({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_STATS_EN
    chk({tag, "_dcnt"},  32'(drop_cnt), 32'(m_drops));
`endif
  endtask

  task automatic step(input string tag, input logic rst_n, input logic wr, input logic [DW-1:0] d,
                      input logic rdy, input logic fl, input logic clr);
    bit do_pop, do_push, do_drop;
    @(negedge clk);
    reset = rst_n; wr_en = wr; wr_data = d; rd_ready = rdy; flush = fl; clr_overflow = clr;
    if (rst_n && !fl && rdy && rd_valid) popped.push_back(rd_data);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); m_ovf = 1'b0; m_drops = 0;
    end else begin
      do_pop  = !fl && rdy && (mq.size() > 0);
      do_push = !fl && wr && (mq.size() < DEPTH || do_pop);
      do_drop = !fl && wr && !do_push;
      if (fl) mq.delete();
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(d);
      m_ovf = do_drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
      if (clr) m_drops = 0;
      else if (do_drop && m_drops < 65535) m_drops++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0; flush = 1'b0; clr_overflow = 1'b0;
    m_ovf = 1'b0; m_drops = 0;

    // 1: reset two cycles, then release
    step("rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step("rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step("idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 2: single push, then head held stable with no consumer
    step("push1", 1'b1, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    chk("push1_head", 32'(rd_data), 32'h31);
    for (int i = 0; i < 5; i++) step("hold", 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0);
    step("drain", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 3: fill, drop one, drain in order
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    step("drop", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    popped.delete();
    for (int i = 0; i < DEPTH; i++) step("popall", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t3_npop", 32'(popped.size()), 32'(DEPTH));
    for (int i = 0; i < popped.size(); i++) chk("t3_order", 32'(popped[i]), 32'(8'h30 + i));
    chk("t3_empty", 32'(empty), 32'd1);
    step("clr", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // 4: push and pop together while full
    for (int i = 0; i < DEPTH; i++) step("fill4", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step("pp_full", 1'b1, 1'b1, 8'h61, 1'b1, 1'b0, 1'b0);
    chk("t4_count", 32'(count), 32'(DEPTH));
    chk("t4_ovf", 32'(overflow), 32'd0);
    popped.delete();
    for (int i = 0; i < DEPTH; i++) step("pop4", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_last", (popped.size() > 0) ? 32'(popped[popped.size()-1]) : 32'hDEAD, 32'h61);

    // 5: flush with a concurrent push, overflow set beforehand
    for (int i = 0; i < DEPTH + 1; i++) step("ovf5", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 3; i++) step("trim5", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("flush", 1'b1, 1'b1, 8'h64, 1'b0, 1'b1, 1'b0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd1);
    step("clr5", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++)
      step("rand", 1'b1, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
           1'b0, 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < DEPTH; i++) step("rdrain", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 6: reset in the middle of activity with overflow set
    for (int i = 0; i < DEPTH + 1; i++) step("fill6", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) step("trim6", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t6_pre_count", 32'(count), 32'd5);
    step("midrst", 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    for (int i = 0; i < DEPTH; i++) step("fillS", 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("dropS", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_STATS_EN
    chk("t6_dcnt3", 32'(drop_cnt), 32'd3);
`endif
    step("clrS", 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    chk("t6_clr_ovf", 32'(overflow), 32'd1);
    step("clrS2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t6_clr_ovf2", 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_STATS_EN
    chk("t6_dcnt0", 32'(drop_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
